data_demultiplex: RTL and testbench

//  Receive end of the data_multiplex time-division link: takes the single 8-bit

---
 rtl/data_mux_pkg.sv | 62 ++++++
 rtl/dwell_counter.sv | 45 ++++
 rtl/data_demultiplex.sv | 136 +++++++++++++
 tb/tb_data_demultiplex.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mux_pkg.sv
// Slot sequencing shared by both ends of the time-division link: mode codes, slot states,
// and the rules for the first, next and last slot of each sequence.
package data_mux_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_FWD    = 2'b01;
    localparam logic [1:0] MODE_REV    = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT1 = 2'd1,
        ST_SLOT2 = 2'd2,
        ST_SLOT3 = 2'd3
    } slot_state_e;

    function automatic slot_state_e first_slot(input logic [1:0] mode);
        slot_state_e s;
        case (mode)
            MODE_FWD, MODE_SINGLE: s = ST_SLOT1;
            MODE_REV:              s = ST_SLOT3;
            default:               s = ST_IDLE;
        endcase
        return s;
    endfunction

    // The slot that follows cur when the sequence being entered is the one selected by mode.
    function automatic slot_state_e next_slot(input slot_state_e cur, input logic [1:0] mode);
        slot_state_e s;
        case (mode)
            MODE_FWD: begin
                case (cur)
                    ST_SLOT1: s = ST_SLOT2;
                    ST_SLOT2: s = ST_SLOT3;
                    default:  s = ST_SLOT1;
                endcase
            end
            MODE_REV: begin
                case (cur)
                    ST_SLOT3: s = ST_SLOT2;
                    ST_SLOT2: s = ST_SLOT1;
                    default:  s = ST_SLOT3;
                endcase
            end
            MODE_SINGLE: s = ST_SLOT1;
            default:     s = ST_IDLE;
        endcase
        return s;
    endfunction

    function automatic logic is_last_slot(input slot_state_e cur, input logic [1:0] mode);
        logic r;
        case (mode)
            MODE_FWD:    r = (cur == ST_SLOT3);
            MODE_REV:    r = (cur == ST_SLOT1);
            MODE_SINGLE: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Per-slot dwell counter: latches dwell length N on load (N=0 runs as N=1) and counts 0..N-1.
// last_cycle is combinational from the current count; there is no flow control.
// Priority: load > clr > en.
module dwell_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] n_in,
    output logic             last_cycle
);

    logic [CNT_W-1:0] count_d, count_q;
    logic [CNT_W-1:0] n_d, n_q;
    logic [CNT_W-1:0] n_eff;

    always_comb begin
        n_eff      = (n_q == '0) ? CNT_W'(1) : n_q;
        last_cycle = (count_q == n_eff - CNT_W'(1));
        count_d    = count_q;
        n_d        = n_q;
        if (load) begin
            count_d = '0;
            n_d     = n_in;
        end else if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = last_cycle ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            n_q     <= '0;
        end else begin
            count_q <= count_d;
            n_q     <= n_d;
        end
    end

endmodule

// File: rtl/data_demultiplex.sv
// Receive-side demultiplexer: routes each dwell slot of the stream to DS1/DS2/DS3.
// Latency 1 cycle from last-dwell sample to DSx_out/ch_valid; no backpressure, stream is free-running.
// Optional DEMUX_FRAME_CNT_EN adds frame_cnt, counting completed slot rotations.
module data_demultiplex
    import data_mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  switch_clk_cycles,
    input  logic              sync,
    output logic [DATA_W-1:0] DS1_out,
    output logic [DATA_W-1:0] DS2_out,
    output logic [DATA_W-1:0] DS3_out,
    output logic [2:0]        ch_valid
`ifdef DEMUX_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    slot_state_e       state_d, state_q;
    slot_state_e       cap_slot;
    logic [1:0]        mode_lat_d, mode_lat_q;
    logic [DATA_W-1:0] ds1_d, ds1_q, ds2_d, ds2_q, ds3_d, ds3_q;
    logic [2:0]        ch_valid_d, ch_valid_q;
    logic              cnt_load, cnt_clr, cnt_en, last_cycle;
    logic              capture;

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .n_in       (switch_clk_cycles),
        .last_cycle (last_cycle)
    );

    // Every slot entry (sync, leaving IDLE, boundary) relatches mode and dwell from the live inputs.
    always_comb begin
        state_d    = state_q;
        mode_lat_d = mode_lat_q;
        cnt_load   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        capture    = 1'b0;
        if (sync) begin
            state_d    = first_slot(mode);
            mode_lat_d = mode;
            cnt_load   = 1'b1;
        end else if (state_q == ST_IDLE) begin
            cnt_clr = 1'b1;
            if (mode != MODE_IDLE) begin
                state_d    = first_slot(mode);
                mode_lat_d = mode;
                cnt_load   = 1'b1;
            end
        end else begin
            cnt_en = 1'b1;
            if (last_cycle) begin
                capture    = 1'b1;
                state_d    = next_slot(state_q, mode);
                mode_lat_d = mode;
                cnt_load   = 1'b1;
            end
        end
    end

    always_comb begin
        ds1_d      = ds1_q;
        ds2_d      = ds2_q;
        ds3_d      = ds3_q;
        ch_valid_d = 3'b000;
        cap_slot   = (mode_lat_q == MODE_SINGLE) ? ST_SLOT1 : state_q;
        if (capture) begin
            case (cap_slot)
                ST_SLOT1: begin ds1_d = data_in; ch_valid_d = 3'b001; end
                ST_SLOT2: begin ds2_d = data_in; ch_valid_d = 3'b010; end
                ST_SLOT3: begin ds3_d = data_in; ch_valid_d = 3'b100; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_lat_q <= MODE_IDLE;
            ds1_q      <= '0;
            ds2_q      <= '0;
            ds3_q      <= '0;
            ch_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_lat_q <= mode_lat_d;
            ds1_q      <= ds1_d;
            ds2_q      <= ds2_d;
            ds3_q      <= ds3_d;
            ch_valid_q <= ch_valid_d;
        end
    end

    assign DS1_out  = ds1_q;
    assign DS2_out  = ds2_q;
    assign DS3_out  = ds3_q;
    assign ch_valid = ch_valid_q;

`ifdef DEMUX_FRAME_CNT_EN
    logic [15:0] frame_d, frame_q;

    always_comb begin
        frame_d = frame_q;
        if (sync) begin
            frame_d = '0;
        end else if (capture && is_last_slot(state_q, mode_lat_q)) begin
            frame_d = frame_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_cnt = frame_q;
`endif

endmodule

// File: tb/tb_data_demultiplex.sv
// Bench for data_demultiplex: directed scenarios then random traffic, each cycle checked
// against a sequence-table reference model.
module tb_data_demultiplex;

    logic       clk = 1'b0;
    logic       rst, sync;
    logic [7:0] data_in;
    logic [1:0] mode;
    logic [3:0] sw;
    logic [7:0] ds1, ds2, ds3;
    logic [2:0] chv;
`ifdef DEMUX_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: m_cur is the channel (0 = idle) whose slot is active.
    int m_cur, m_cnt, m_dwell, m_lmode, m_vld, m_frame;
    int m_ds [1:3];

    always #5 clk = ~clk;

    data_demultiplex #(.DATA_W(8), .CNT_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .mode              (mode),
        .switch_clk_cycles (sw),
        .sync              (sync),
        .DS1_out           (ds1),
        .DS2_out           (ds2),
        .DS3_out           (ds3),
        .ch_valid          (chv)
`ifdef DEMUX_FRAME_CNT_EN
        ,
        .frame_cnt         (frame_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Channel order of each mode: fwd 1,2,3; rev 3,2,1; single 1.
    function automatic int seq_len(input int md);
        return (md == 3) ? 1 : 3;
    endfunction

    function automatic int seq_at(input int md, input int i);
        if (md == 1) return i + 1;
        if (md == 2) return 3 - i;
        return 1;
    endfunction

    function automatic int pos_of(input int md, input int ch);
        if (md == 1) return ch - 1;
        if (md == 2) return 3 - ch;
        return 0;
    endfunction

    task automatic model_enter(input int md, input int ch, input int n);
        m_cur   = (md == 0) ? 0 : ch;
        m_cnt   = 0;
        m_dwell = (n == 0) ? 1 : n;
        m_lmode = md;
    endtask

    task automatic model_step();
        int ch;
        m_vld = 0;
        if (rst) begin
            m_cur = 0; m_cnt = 0; m_dwell = 1; m_lmode = 0; m_frame = 0;
            m_ds[1] = 0; m_ds[2] = 0; m_ds[3] = 0;
        end else if (sync) begin
            m_frame = 0;
            model_enter(int'(mode), seq_at(int'(mode), 0), int'(sw));
        end else if (m_cur == 0) begin
            if (mode != 2'b00) model_enter(int'(mode), seq_at(int'(mode), 0), int'(sw));
        end else if (m_cnt == m_dwell - 1) begin
            ch = (m_lmode == 3) ? 1 : m_cur;
            m_ds[ch] = int'(data_in);
            m_vld = 1 << (ch - 1);
            if (pos_of(m_lmode, m_cur) == seq_len(m_lmode) - 1) m_frame = (m_frame + 1) % 65536;
            model_enter(int'(mode),
                        seq_at(int'(mode), (pos_of(int'(mode), m_cur) + 1) % seq_len(int'(mode))),
                        int'(sw));
        end else begin
            m_cnt++;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ds1", 32'(ds1), m_ds[1]);
        check_eq("ds2", 32'(ds2), m_ds[2]);
        check_eq("ds3", 32'(ds3), m_ds[3]);
        check_eq("ch_valid", 32'(chv), m_vld);
`ifdef DEMUX_FRAME_CNT_EN
        check_eq("frame_cnt", 32'(frame_cnt), m_frame);
`endif
    endtask

    task automatic do_sync(input logic [1:0] md, input logic [3:0] n);
        mode = md; sw = n; sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    initial begin
        logic [7:0] pat3 [3];
        rst = 1'b1; sync = 1'b0; data_in = 8'hAA; mode = 2'b00; sw = 4'd0;

        // Reset held with live data on the stream.
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_vld", 32'(chv), 0);
            check_eq("rst_ds1", 32'(ds1), 0);
        end
        rst = 1'b0;

        // Forward, dwell 6.
        pat3[0] = 8'hAA; pat3[1] = 8'hBB; pat3[2] = 8'hCC;
        do_sync(2'b01, 4'd6);
        for (int s = 0; s < 3; s++) begin
            data_in = pat3[s];
            for (int c = 0; c < 6; c++) step();
        end
        check_eq("fwd_ds1", 32'(ds1), 32'hAA);
        check_eq("fwd_ds2", 32'(ds2), 32'hBB);
        check_eq("fwd_ds3", 32'(ds3), 32'hCC);
        check_eq("fwd_vld", 32'(chv), 32'h4);

        // Reverse, dwell 3.
        pat3[0] = 8'h11; pat3[1] = 8'h22; pat3[2] = 8'h33;
        do_sync(2'b10, 4'd3);
        for (int s = 0; s < 3; s++) begin
            data_in = pat3[s];
            for (int c = 0; c < 3; c++) step();
        end
        check_eq("rev_ds3", 32'(ds3), 32'h11);
        check_eq("rev_ds2", 32'(ds2), 32'h22);
        check_eq("rev_ds1", 32'(ds1), 32'h33);
        check_eq("rev_vld", 32'(chv), 32'h1);

        // Mode and dwell changed mid-slot: slot finishes at 6, then reverse at 3.
        do_sync(2'b01, 4'd6);
        data_in = 8'h40;
        step(); step();
        mode = 2'b10; sw = 4'd3;
        for (int c = 0; c < 4; c++) step();
        check_eq("chg_ds1", 32'(ds1), 32'h40);
        check_eq("chg_vld1", 32'(chv), 32'h1);
        data_in = 8'h41;
        for (int c = 0; c < 3; c++) step();
        check_eq("chg_ds3", 32'(ds3), 32'h41);
        check_eq("chg_vld3", 32'(chv), 32'h4);

        // N=0 in single mode: DS1 every cycle.
        do_sync(2'b11, 4'd0);
        for (int i = 0; i < 20; i++) begin
            data_in = 8'(i);
            step();
            check_eq("single_vld", 32'(chv), 32'h1);
            check_eq("single_ds1", 32'(ds1), i);
        end

        // Sync landing on the capture cycle drops that capture.
        do_sync(2'b01, 4'd4);
        data_in = 8'h5A;
        step(); step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("syncdrop_vld", 32'(chv), 0);
        check_eq("syncdrop_ds1", 32'(ds1), 32'h13);
`ifdef DEMUX_FRAME_CNT_EN
        check_eq("syncdrop_frame0", 32'(frame_cnt), 0);
`endif
        for (int c = 0; c < 12; c++) step();
        check_eq("syncdrop_vld3", 32'(chv), 32'h4);
`ifdef DEMUX_FRAME_CNT_EN
        check_eq("syncdrop_frame1", 32'(frame_cnt), 1);
`endif

        // Random traffic with occasional mode/dwell changes, syncs and resets.
        for (int i = 0; i < 4000; i++) begin
            data_in = 8'($urandom);
            rst     = ($urandom_range(0, 299) == 0);
            sync    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) sw = 4'($urandom_range(0, 6));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
